// File: rtl/param_step_cpu_pkg.sv
// Shared opcode and FSM state encodings for the parametrised step CPU.
package param_step_cpu_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_SUB    = 4'h2;
    localparam logic [3:0] OP_NOT    = 4'h3;
    localparam logic [3:0] OP_AND    = 4'h4;
    localparam logic [3:0] OP_OR     = 4'h5;
    localparam logic [3:0] OP_XOR    = 4'h6;
    localparam logic [3:0] OP_INC    = 4'h7;
    localparam logic [3:0] OP_MOVI   = 4'h8;
    localparam logic [3:0] OP_MOV    = 4'h9;
    localparam logic [3:0] OP_SHL    = 4'hA;
    localparam logic [3:0] OP_SHR    = 4'hB;
    localparam logic [3:0] OP_CMP    = 4'hC;
    localparam logic [3:0] OP_RSVD_D = 4'hD;
    localparam logic [3:0] OP_RSVD_E = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB     = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

endpackage

// File: rtl/param_step_cpu_alu.sv
// Combinational ALU: result, carry and the write/flag enables for one opcode.
module param_step_cpu_alu
    import param_step_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] s,
    input  logic [REG_AW-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              c_out,
    output logic              wr_en,
    output logic              flag_en,
    output logic              illegal
);

    // One extra bit catches carry-out on add and borrow on subtract.
    logic [DATA_W:0] wide;

    // Opcode decode and datapath.
    always_comb begin
        wide    = '0;
        result  = '0;
        c_out   = 1'b0;
        wr_en   = 1'b0;
        flag_en = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                wide    = {1'b0, d} + {1'b0, s};
                result  = wide[DATA_W-1:0];
                c_out   = wide[DATA_W];
                wr_en   = 1'b1;
                flag_en = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                wide    = {1'b0, d} - {1'b0, s};
                result  = wide[DATA_W-1:0];
                c_out   = wide[DATA_W];
                wr_en   = (op == OP_SUB);
                flag_en = 1'b1;
            end
            OP_NOT: begin result = ~d;    wr_en = 1'b1; flag_en = 1'b1; end
            OP_AND: begin result = d & s; wr_en = 1'b1; flag_en = 1'b1; end
            OP_OR:  begin result = d | s; wr_en = 1'b1; flag_en = 1'b1; end
            OP_XOR: begin result = d ^ s; wr_en = 1'b1; flag_en = 1'b1; end
            OP_INC: begin
                wide    = {1'b0, d} + {{DATA_W{1'b0}}, 1'b1};
                result  = wide[DATA_W-1:0];
                c_out   = wide[DATA_W];
                wr_en   = 1'b1;
                flag_en = 1'b1;
            end
            OP_MOVI: begin result = DATA_W'(imm); wr_en = 1'b1; flag_en = 1'b1; end
            OP_MOV:  begin result = s;            wr_en = 1'b1; flag_en = 1'b1; end
            OP_SHL: begin
                result  = {d[DATA_W-2:0], 1'b0};
                c_out   = d[DATA_W-1];
                wr_en   = 1'b1;
                flag_en = 1'b1;
            end
            OP_SHR: begin
                result  = {1'b0, d[DATA_W-1:1]};
                c_out   = d[0];
                wr_en   = 1'b1;
                flag_en = 1'b1;
            end
            OP_RSVD_D, OP_RSVD_E: illegal = 1'b1;
            default: ;  // NOP and HALT touch neither registers nor flags
        endcase
    end

endmodule

// File: rtl/param_step_cpu.sv
// Step CPU core: handshake-fed DECODE/EXEC/WB pipeline over a small register file.
module param_step_cpu
    import param_step_cpu_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int REG_AW   = 2,
    parameter  int PC_W     = 8,
    localparam int NUM_REGS = 2**REG_AW,
    localparam int INSTR_W  = 4 + 2*REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               done,
    output logic               halted,
    output logic               illegal,
    output logic [PC_W-1:0]    pc,
    output logic               flag_z,
    output logic               flag_c,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [DATA_W-1:0]  out_port
);

    logic [2:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  opd_q, ops_q, res_q;
    logic               cout_q, wr_q, fl_q, ill_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [PC_W-1:0]    pc_q;
    logic               z_q, c_q, done_q, illegal_q, halted_q;

    logic [3:0]         op;
    logic [REG_AW-1:0]  dst, src;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_c, alu_wr, alu_fl, alu_ill;
    logic               accept;

    assign op     = instr_q[INSTR_W-1 -: 4];
    assign dst    = instr_q[2*REG_AW-1 -: REG_AW];
    assign src    = instr_q[REG_AW-1:0];
    assign accept = instr_valid & instr_ready;

    // Register 0 reads as zero regardless of storage.
    function automatic logic [DATA_W-1:0] rd(input logic [REG_AW-1:0] idx);
        return (idx == '0) ? '0 : regs_q[idx];
    endfunction

    param_step_cpu_alu #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_alu (
        .op(op), .d(opd_q), .s(ops_q), .imm(src),
        .result(alu_res), .c_out(alu_c), .wr_en(alu_wr),
        .flag_en(alu_fl), .illegal(alu_ill)
    );

    // Next-state logic; HALTED is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = (op == OP_HALT) ? ST_HALTED : ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pipeline registers, register file, pc and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            opd_q     <= '0;
            ops_q     <= '0;
            res_q     <= '0;
            cout_q    <= 1'b0;
            wr_q      <= 1'b0;
            fl_q      <= 1'b0;
            ill_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pc_q      <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) instr_q <= instr;
                ST_DECODE: begin
                    opd_q <= rd(dst);
                    ops_q <= rd(src);
                end
                ST_EXEC: begin
                    res_q  <= alu_res;
                    cout_q <= alu_c;
                    wr_q   <= alu_wr;
                    fl_q   <= alu_fl;
                    ill_q  <= alu_ill;
                end
                ST_WB: begin
                    if (wr_q && dst != '0) regs_q[dst] <= res_q;
                    if (fl_q) begin
                        z_q <= (res_q == '0);
                        c_q <= cout_q;
                    end
                    pc_q      <= pc_q + 1'b1;
                    done_q    <= 1'b1;
                    illegal_q <= ill_q;
                    if (op == OP_HALT) halted_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;
    assign pc          = pc_q;
    assign flag_z      = z_q;
    assign flag_c      = c_q;
    assign dbg_data    = rd(dbg_sel);
    assign out_port    = regs_q[NUM_REGS-1];

endmodule

// File: tb/tb_param_step_cpu.sv
// Scoreboard bench for param_step_cpu: a reference model predicts each retirement.
module tb_param_step_cpu;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 2;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [INSTR_W-1:0] instr = '0;
    logic               instr_valid = 1'b0;
    logic               instr_ready, done, halted, illegal, flag_z, flag_c;
    logic [PC_W-1:0]    pc;
    logic [REG_AW-1:0]  dbg_sel = '0;
    logic [DATA_W-1:0]  dbg_data, out_port;

    param_step_cpu #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .done(done), .halted(halted), .illegal(illegal),
        .pc(pc), .flag_z(flag_z), .flag_c(flag_c), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [1:0] dst;
        logic [7:0] dval;
        logic [7:0] r3;
        logic [7:0] pc;
        logic       z, c, ill, hlt;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_r [4];
    logic       m_z, m_c, m_h;
    logic [7:0] m_pc;
    int         last_acc;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_z = 1'b0; m_c = 1'b0; m_h = 1'b0; m_pc = 8'h00;
    endtask

    // Drive one instruction from a negedge, wait for acceptance, predict its retirement.
    task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input bit hold);
        int k;
        logic [7:0] d, s, r;
        logic [8:0] w;
        logic       c, wr, fl;
        exp_t       e;
        k = 0;
        instr = {op, dst, src};
        instr_valid = 1'b1;
        while (!instr_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        d = (dst == 2'd0) ? 8'h00 : m_r[dst];
        s = (src == 2'd0) ? 8'h00 : m_r[src];
        r = 8'h00; c = 1'b0; wr = 1'b1; fl = 1'b1; w = 9'h000;
        case (op)
            4'h1: begin w = d + s; r = w[7:0]; c = w[8]; end
            4'h2: begin r = d - s; c = (d < s); end
            4'h3: r = ~d;
            4'h4: r = d & s;
            4'h5: r = d | s;
            4'h6: r = d ^ s;
            4'h7: begin r = d + 8'h01; c = (d == 8'hFF); end
            4'h8: r = {6'b0, src};
            4'h9: r = s;
            4'hA: begin r = {d[6:0], 1'b0}; c = d[7]; end
            4'hB: begin r = {1'b0, d[7:1]}; c = d[0]; end
            4'hC: begin r = d - s; c = (d < s); wr = 1'b0; end
            default: begin wr = 1'b0; fl = 1'b0; end
        endcase
        if (wr && dst != 2'd0) m_r[dst] = r;
        if (fl) begin m_z = (r == 8'h00); m_c = c; end
        m_pc = m_pc + 8'h01;
        if (op == 4'hF) m_h = 1'b1;
        e.cyc  = cyc + 4;
        e.dst  = dst;
        e.dval = (dst == 2'd0) ? 8'h00 : m_r[dst];
        e.r3   = m_r[3];
        e.pc   = m_pc;
        e.z    = m_z;
        e.c    = m_c;
        e.ill  = (op == 4'hD || op == 4'hE);
        e.hlt  = m_h;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Monitor: every done pulse retires the oldest scoreboard entry.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    dbg_sel = e.dst;
                    #1;
                    chk("latency", cyc, e.cyc);
                    chk("dst_val", dbg_data, e.dval);
                    chk("out_port", out_port, e.r3);
                    chk("pc", pc, e.pc);
                    chk("flag_z", flag_z, e.z);
                    chk("flag_c", flag_c, e.c);
                    chk("illegal", illegal, e.ill);
                    chk("halted", halted, e.hlt);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int a;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_pc", pc, 8'h00);
        chk("rst_done", done, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Test 2: basic add
        issue(4'h8, 2'd1, 2'd3, 0);
        issue(4'h8, 2'd2, 2'd2, 0);
        issue(4'h1, 2'd1, 2'd2, 0);
        drain();

        // Test 1: reset while an instruction is in EXEC
        issue(4'h8, 2'd3, 2'd3, 0);   // now in DECODE
        @(negedge clk);               // now in EXEC
        rst = 1'b0;
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_ready", instr_ready, 1'b1);
        chk("reset_pc", pc, 8'h00);
        chk("reset_z", flag_z, 1'b0);
        chk("reset_c", flag_c, 1'b0);
        chk("reset_halted", halted, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0];
            #1;
            chk("reset_reg", dbg_data, 8'h00);
        end
        @(negedge clk);

        // Test 2 again from clean state, then test 3: subtract and borrow
        issue(4'h8, 2'd1, 2'd3, 0);
        issue(4'h8, 2'd2, 2'd2, 0);
        issue(4'h1, 2'd1, 2'd2, 0);
        issue(4'h8, 2'd3, 2'd1, 0);
        issue(4'h2, 2'd3, 2'd3, 0);
        issue(4'h8, 2'd3, 2'd1, 0);
        issue(4'h8, 2'd2, 2'd0, 0);
        issue(4'h2, 2'd2, 2'd3, 0);
        issue(4'hC, 2'd1, 2'd3, 0);
        drain();

        // Test 4: wrap on INC, shift out of MSB, logic ops, out_port
        issue(4'h8, 2'd1, 2'd0, 0);
        issue(4'h3, 2'd1, 2'd0, 0);
        issue(4'h7, 2'd1, 2'd0, 0);
        issue(4'h8, 2'd1, 2'd1, 0);
        for (int i = 0; i < 8; i++) issue(4'hA, 2'd1, 2'd0, 0);
        issue(4'h8, 2'd3, 2'd3, 0);
        issue(4'h1, 2'd3, 2'd3, 0);
        issue(4'hB, 2'd3, 2'd0, 0);
        issue(4'h9, 2'd1, 2'd3, 0);
        issue(4'h6, 2'd1, 2'd2, 0);
        issue(4'h4, 2'd2, 2'd3, 0);
        issue(4'h5, 2'd2, 2'd1, 0);
        drain();

        // Test 5: continuous valid, writes to r0, reserved opcodes
        issue(4'h8, 2'd0, 2'd3, 1);
        a = last_acc;
        issue(4'h1, 2'd0, 2'd3, 1);
        chk("accept_gap", last_acc - a, 4);
        a = last_acc;
        issue(4'hD, 2'd3, 2'd1, 1);
        chk("accept_gap", last_acc - a, 4);
        a = last_acc;
        issue(4'hE, 2'd2, 2'd1, 1);
        chk("accept_gap", last_acc - a, 4);
        issue(4'h0, 2'd1, 2'd1, 0);
        drain();

        // Test 6: HALT is terminal
        issue(4'hF, 2'd0, 2'd0, 0);
        drain();
        instr = 8'h81;
        instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_ready", instr_ready, 1'b0);
        end
        instr_valid = 1'b0;
        chk("halt_flag", halted, 1'b1);

        // pc wraps from 0xFF to 0x00
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 255; i++) issue(4'h0, 2'd0, 2'd0, 1);
        instr_valid = 1'b0;
        drain();
        chk("pc_ff", pc, 8'hFF);
        issue(4'h0, 2'd1, 2'd2, 0);
        drain();
        chk("pc_wrap", pc, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
